// File: rtl/ofm_burst_packer_if.sv
// Bundle of the OFM input, output stream and write-master signals of the burst packer.
interface ofm_burst_packer_if #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 256
);
    localparam int WORD_W = NUM_CH * CH_W;

    logic [NUM_CH-1:0]      ofm_port_v;
    logic [NUM_CH*CH_W-1:0] ofm_port;
    logic [NUM_CH-1:0]      ofm_port_rdy;
    logic                   end_conv;
    logic [WORD_W-1:0]      tdata;
    logic                   tvalid;
    logic                   tready;
    logic [63:0]            wmst_offset;
    logic                   wmst_req;
    logic [63:0]            wmst_addr;
    logic [63:0]            wmst_xfer_size;
    logic                   wmst_done;
    logic                   conv_wr_done;
    logic                   write_buffer_wait;
    logic                   err_partial;

    // Packer side
    modport slave (
        input  ofm_port_v, ofm_port, end_conv, tready, wmst_offset, wmst_done,
        output ofm_port_rdy, tdata, tvalid, wmst_req, wmst_addr, wmst_xfer_size,
        output conv_wr_done, write_buffer_wait, err_partial
    );

    // Environment side (OFM producer, stream sink, write master)
    modport master (
        output ofm_port_v, ofm_port, end_conv, tready, wmst_offset, wmst_done,
        input  ofm_port_rdy, tdata, tvalid, wmst_req, wmst_addr, wmst_xfer_size,
        input  conv_wr_done, write_buffer_wait, err_partial
    );
endinterface

// File: rtl/ofm_burst_packer.sv
// Packs per-channel OFM data into full-width words, buffers them in a
// fall-through FIFO and sequences write bursts covering the buffered words.
//
// state | meaning
// IDLE  | wait for enough words (or end of layer) to issue a burst
// REQ   | one-cycle burst request with registered address/size
// BUSY  | wait for the write master to finish the burst
// FIN   | one-cycle layer completion, address counter rewinds
module ofm_burst_packer #(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 256,
    parameter int BURST_WORDS = 16,
    parameter int ADDR_BITS   = 9
) (
    input logic              clk,
    input logic              rst,
    ofm_burst_packer_if.slave bus
);
    localparam int WORD_W    = NUM_CH * CH_W;
    localparam int WORD_BYTE = WORD_W / 8;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int PW        = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, REQ, BUSY, FIN} state_t;

    state_t                       state_q, state_d;
    logic [NUM_CH-1:0]            hold_v_q, hold_v_d;
    logic [NUM_CH-1:0][CH_W-1:0]  hold_q, hold_d;
    logic [WORD_W-1:0]            fifo_mem [DEPTH];
    logic [ADDR_BITS-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                count_q, count_d;
    logic [PW-1:0]                pend_q, pend_d, len_q, len_d;
    logic [31:0]                  addr_cnt_q, addr_cnt_d;
    logic                         end_flag_q, end_flag_d;
    logic                         err_partial_q, err_partial_d;
    logic [63:0]                  wmst_addr_q, wmst_addr_d, wmst_xfer_size_q, wmst_xfer_size_d;

    logic                         fifo_full, fifo_empty, pad, push, pop, issue;
    logic [NUM_CH-1:0]            rdy;
    logic [WORD_W-1:0]            push_word;

    // Hold registers, word assembly (channel 0 in the MSBs, empty channels zero) and FIFO pointers
    always_comb begin
        fifo_full  = (count_q == PW'(DEPTH));
        fifo_empty = (count_q == '0);
        // A lone partial word at end of layer is flushed only once the producers have gone quiet
        pad        = end_flag_q && (hold_v_q != '0) && !(&hold_v_q) && (bus.ofm_port_v == '0);
        push       = ((&hold_v_q) || pad) && !fifo_full;
        pop        = !fifo_empty && bus.tready;
        push_word  = '0;
        hold_v_d   = hold_v_q;
        hold_d     = hold_q;
        rdy        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hold_v_q[i]) begin
                push_word[WORD_W-1-i*CH_W -: CH_W] = hold_q[i];
            end
            rdy[i] = !hold_v_q[i] || push;
            if (bus.ofm_port_v[i] && rdy[i]) begin
                hold_v_d[i] = 1'b1;
                hold_d[i]   = bus.ofm_port[i*CH_W +: CH_W];
            end else if (push) begin
                hold_v_d[i] = 1'b0;
            end
        end
        wr_ptr_d      = wr_ptr_q + ADDR_BITS'(push);
        rd_ptr_d      = rd_ptr_q + ADDR_BITS'(pop);
        count_d       = count_q + PW'(push) - PW'(pop);
        err_partial_d = err_partial_q || (pad && push);
    end

    // Burst sequencer: next state, burst length/address and pending-word accounting
    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        addr_cnt_d       = addr_cnt_q;
        end_flag_d       = end_flag_q || bus.end_conv;
        wmst_addr_d      = wmst_addr_q;
        wmst_xfer_size_d = wmst_xfer_size_q;
        issue            = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q >= PW'(BURST_WORDS)) begin
                    issue   = 1'b1;
                    len_d   = PW'(BURST_WORDS);
                    state_d = REQ;
                end else if (end_flag_q && hold_v_q == '0 && pend_q != '0) begin
                    issue   = 1'b1;
                    len_d   = pend_q;
                    state_d = REQ;
                end else if (end_flag_q && hold_v_q == '0) begin
                    state_d = FIN;
                end
                if (issue) begin
                    wmst_addr_d      = bus.wmst_offset + 64'(addr_cnt_q) * 64'(WORD_BYTE);
                    wmst_xfer_size_d = 64'(len_d) * 64'(WORD_BYTE);
                end
            end
            REQ: state_d = BUSY;
            BUSY: begin
                if (bus.wmst_done) begin
                    addr_cnt_d = addr_cnt_q + 32'(len_q);
                    state_d    = IDLE;
                end
            end
            FIN: begin
                addr_cnt_d = '0;
                end_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pend_d = pend_q + PW'(push) - (issue ? len_d : '0);
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            hold_v_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            pend_q           <= '0;
            len_q            <= '0;
            addr_cnt_q       <= '0;
            end_flag_q       <= 1'b0;
            err_partial_q    <= 1'b0;
            wmst_addr_q      <= '0;
            wmst_xfer_size_q <= '0;
        end else begin
            state_q          <= state_d;
            hold_v_q         <= hold_v_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            pend_q           <= pend_d;
            len_q            <= len_d;
            addr_cnt_q       <= addr_cnt_d;
            end_flag_q       <= end_flag_d;
            err_partial_q    <= err_partial_d;
            wmst_addr_q      <= wmst_addr_d;
            wmst_xfer_size_q <= wmst_xfer_size_d;
        end
    end

    // Data storage needs no reset; validity is carried by hold_v_q and the FIFO count
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    assign bus.ofm_port_rdy      = rdy;
    assign bus.tvalid            = !fifo_empty;
    assign bus.tdata             = fifo_mem[rd_ptr_q];
    assign bus.wmst_req          = (state_q == REQ);
    assign bus.wmst_addr         = wmst_addr_q;
    assign bus.wmst_xfer_size    = wmst_xfer_size_q;
    assign bus.conv_wr_done      = (state_q == FIN);
    assign bus.write_buffer_wait = !fifo_empty || end_flag_q || (state_q != IDLE);
    assign bus.err_partial       = err_partial_q;
endmodule
